// File: rtl/aes_pkg.sv
// AES helper package: GF(2^8) arithmetic, S-box, rcon constants and scheduler state type.
// Contents:
//   KEY_W/WORD_W/BYTE_W/IDX_W  widths of key, word, byte and round index
//   RCON_FIRST/RCON_LAST       rcon of round 1 and round 10
//   state_t                    scheduler FSM states
//   xtime/inv_xtime/sbox       byte functions used by the key step
package aes_pkg;

   localparam int unsigned KEY_W  = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned IDX_W  = 4;

   localparam logic [BYTE_W-1:0] RCON_FIRST = 8'h01;
   localparam logic [BYTE_W-1:0] RCON_LAST  = 8'h36;

   typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   // Divide by x in GF(2^8); exact inverse of xtime.
   function automatic logic [7:0] inv_xtime(input logic [7:0] x);
      return x[0] ? (((x ^ 8'h1B) >> 1) | 8'h80) : (x >> 1);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] y;
      logic [7:0] r;
      y = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         y = gf_mul(y, y);
         r = gf_mul(r, y);
      end
      return r;
   endfunction

   // Forward S-box: inverse followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step, forward or inverse, sharing a single 4-byte S-box set.
// Ports:
//   key       in   current round key (w0 in [127:96] ... w3 in [31:0])
//   rcon      in   rcon of the round being produced (fwd) or undone (inv)
//   dir       in   0 = forward step, 1 = inverse step
//   next_key  out  resulting round key
module aes_key_step
   import aes_pkg::*;
(
   input  logic [KEY_W-1:0]  key,
   input  logic [BYTE_W-1:0] rcon,
   input  logic              dir,
   output logic [KEY_W-1:0]  next_key
);

   logic [WORD_W-1:0] w0, w1, w2, w3;
   logic [WORD_W-1:0] sb_in, rot, t;

   assign w0 = key[127:96];
   assign w1 = key[95:64];
   assign w2 = key[63:32];
   assign w3 = key[31:0];

   // The inverse step needs SubWord of the recovered w3 (w3^w2), the forward step of w3 itself.
   assign sb_in = dir ? (w3 ^ w2) : w3;
   assign rot   = {sb_in[23:0], sb_in[31:24]};
   assign t     = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

   always_comb begin
      logic [WORD_W-1:0] f0, f1, f2, f3;
      f0 = w0 ^ t;
      f1 = w1 ^ f0;
      f2 = w2 ^ f1;
      f3 = w3 ^ f2;
      next_key = {f0, f1, f2, f3};
      if (dir) next_key = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};
   end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: expands the cipher key forward to round 10, then
// streams round keys 10..0 over a valid/ready interface using inverse expansion steps.
// Optional feature macro: AES_INV_KEY_CACHE_EN (caches the last key and its round-10 key
// so a repeated start skips the expansion phase).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, key_in   begin a schedule for key_in (accepted only when idle)
//   busy            high whenever not idle
//   rk_valid/ready  round-key stream handshake
//   round_key       current round key
//   round_idx       round number of round_key (10..0)
//   rk_last         marks round 0
module aes_inv_key_sched
   import aes_pkg::*;
#(
   parameter int unsigned NR = 10,   // only 10 is supported
   parameter int unsigned KW = 128   // only 128 is supported
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [KW-1:0] key_in,
   output logic          busy,
   output logic          rk_valid,
   input  logic          rk_ready,
   output logic [KW-1:0] round_key,
   output logic [3:0]    round_idx,
   output logic          rk_last
);

   state_t              state, state_nxt;
   logic [KW-1:0]       key_nxt, step_out;
   logic [BYTE_W-1:0]   rcon, rcon_nxt;
   logic [IDX_W-1:0]    cnt, cnt_nxt, idx_nxt;
   logic                valid_nxt, step_dir;
   logic                cache_hit;
   logic [KW-1:0]       cache_rk10;

   aes_key_step u_step (
      .key      (round_key),
      .rcon     (rcon),
      .dir      (step_dir),
      .next_key (step_out)
   );

`ifdef AES_INV_KEY_CACHE_EN
   logic [KW-1:0] cache_key;
   logic          cache_ok;

   assign cache_hit = cache_ok && (key_in == cache_key);

   // Remember the key of a full expansion and, when it completes, its round-10 key.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_key  <= '0;
         cache_rk10 <= '0;
         cache_ok   <= 1'b0;
      end else if (state == IDLE && start && !cache_hit) begin
         cache_key <= key_in;
         cache_ok  <= 1'b0;
      end else if (state == EXPAND && cnt == IDX_W'(NR)) begin
         cache_rk10 <= step_out;
         cache_ok   <= 1'b1;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_rk10 = '0;
`endif

   // Next-state, key, rcon and stream control.
   always_comb begin
      state_nxt = state;
      key_nxt   = round_key;
      rcon_nxt  = rcon;
      cnt_nxt   = cnt;
      idx_nxt   = round_idx;
      valid_nxt = rk_valid;
      step_dir  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (cache_hit) begin
                  key_nxt   = cache_rk10;
                  rcon_nxt  = RCON_LAST;
                  idx_nxt   = IDX_W'(NR);
                  valid_nxt = 1'b1;
                  state_nxt = EMIT;
               end else begin
                  key_nxt   = key_in;
                  rcon_nxt  = RCON_FIRST;
                  cnt_nxt   = IDX_W'(1);
                  state_nxt = EXPAND;
               end
            end
         end
         EXPAND: begin
            key_nxt = step_out;
            // rcon stops advancing on the last step so it holds the round-10 value for EMIT.
            if (cnt == IDX_W'(NR)) begin
               idx_nxt   = IDX_W'(NR);
               valid_nxt = 1'b1;
               state_nxt = EMIT;
            end else begin
               rcon_nxt = xtime(rcon);
               cnt_nxt  = cnt + IDX_W'(1);
            end
         end
         EMIT: begin
            step_dir = 1'b1;
            if (rk_ready) begin
               if (round_idx == '0) begin
                  valid_nxt = 1'b0;
                  state_nxt = IDLE;
               end else begin
                  key_nxt  = step_out;
                  idx_nxt  = round_idx - IDX_W'(1);
                  rcon_nxt = inv_xtime(rcon);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         round_key <= '0;
         rcon      <= '0;
         cnt       <= '0;
         round_idx <= '0;
         rk_valid  <= 1'b0;
         rk_last   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         round_key <= key_nxt;
         rcon      <= rcon_nxt;
         cnt       <= cnt_nxt;
         round_idx <= idx_nxt;
         rk_valid  <= valid_nxt;
         rk_last   <= valid_nxt && (idx_nxt == '0);
         busy      <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched: a FIPS-197 style word-wise key expansion model
// predicts the reverse-order round-key stream; a negedge monitor pops and compares.
module tb_aes_inv_key_sched;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
`ifdef AES_INV_KEY_CACHE_EN
   localparam int HIT_LAT = 1;
`else
   localparam int HIT_LAT = 11;
`endif

   logic clk = 1'b0;
   logic rst, start, rk_ready, busy, rk_valid, rk_last;
   logic [127:0] key_in, round_key;
   logic [3:0] round_idx;

   always #5 clk = ~clk;

   aes_inv_key_sched dut (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
      .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
      .round_idx(round_idx), .rk_last(rk_last)
   );

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
      logic         last;
   } exp_t;

   exp_t sb[$];
   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int sbt[256];
   int rc[11];
   bit rand_ready = 1'b0;
   logic [127:0] cap10, cap1, cap0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference arithmetic: plain integer GF(2^8) product.
   function automatic int mmul(input int a, input int b);
      int p = 0;
      for (int i = 0; i < 8; i++) begin
         if ((b & 1) != 0) p = p ^ a;
         a = a << 1;
         if ((a & 256) != 0) a = a ^ 'h11B;
         b = b >> 1;
      end
      return p;
   endfunction

   // Build the S-box table by searching for inverses, then applying the affine map bit by bit.
   task automatic build_tables();
      for (int x = 0; x < 256; x++) begin
         int inv = 0;
         int s = 0;
         for (int y = 1; y < 256; y++) if (mmul(x, y) == 1) inv = y;
         for (int i = 0; i < 8; i++) begin
            int bit_v;
            bit_v = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8))
                     ^ (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
            s = s | (bit_v << i);
         end
         sbt[x] = s;
      end
      rc[0] = 0;
      rc[1] = 1;
      for (int i = 2; i <= 10; i++) rc[i] = mmul(rc[i-1], 2);
   endtask

   function automatic logic [31:0] sub_rot(input logic [31:0] w);
      logic [31:0] r;
      r = {w[23:0], w[31:24]};
      return {8'(sbt[r[31:24]]), 8'(sbt[r[23:16]]), 8'(sbt[r[15:8]]), 8'(sbt[r[7:0]])};
   endfunction

   // Standard 44-word expansion; queue keys in emission order 10..0.
   task automatic push_expected(input logic [127:0] k);
      logic [31:0] w[44];
      exp_t e;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         logic [31:0] tmp;
         tmp = w[i-1];
         if (i % 4 == 0) tmp = sub_rot(tmp) ^ {8'(rc[i/4]), 24'h0};
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 10; r >= 0; r--) begin
         e.idx  = 4'(r);
         e.key  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         e.last = (r == 0);
         sb.push_back(e);
      end
   endtask

   // Monitor: compare each accepted key, stall stability, rcon, and idle after the last key.
   bit stalled = 1'b0;
   bit post_last = 1'b0;
   logic [127:0] hold_key;
   logic [3:0] hold_idx;
   logic hold_last;
   always @(negedge clk) begin
      if (rst) begin
         stalled   = 1'b0;
         post_last = 1'b0;
      end else begin
         if (post_last) begin
            check("busy_after_last", 128'(busy), 128'(0));
            check("valid_after_last", 128'(rk_valid), 128'(0));
            post_last = 1'b0;
         end
         if (stalled) begin
            check("stall_valid", 128'(rk_valid), 128'(1));
            check("stall_key", round_key, hold_key);
            check("stall_idx", 128'(round_idx), 128'(hold_idx));
            check("stall_last", 128'(rk_last), 128'(hold_last));
         end
         if (rk_valid && rk_ready) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_key: got idx %0d, expected no key", round_idx);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rk_idx", 128'(round_idx), 128'(e.idx));
               check("rk_key", round_key, e.key);
               check("rk_last", 128'(rk_last), 128'(e.last));
               if (e.idx != 0) check("rcon", 128'(dut.rcon), 128'(rc[e.idx]));
            end
            if (round_idx == 4'd10) cap10 = round_key;
            if (round_idx == 4'd1) cap1 = round_key;
            if (round_idx == 4'd0) begin
               cap0 = round_key;
               post_last = 1'b1;
            end
         end
         stalled   = rk_valid && !rk_ready;
         hold_key  = round_key;
         hold_idx  = round_idx;
         hold_last = rk_last;
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 128'(busy), 128'(0));
      check({tag, "_valid"}, 128'(rk_valid), 128'(0));
      check({tag, "_key"}, round_key, 128'(0));
      check({tag, "_idx"}, 128'(round_idx), 128'(0));
      check({tag, "_last"}, 128'(rk_last), 128'(0));
      check({tag, "_rcon"}, 128'(dut.rcon), 128'(0));
   endtask

   // Issue one schedule, measure first-key latency, optionally poke start while busy, drain.
   task automatic run_key(input logic [127:0] k, input int exp_lat, input bit inject);
      int n;
      int t0;
      @(posedge clk); #1;
      start  = 1'b1;
      key_in = k;
      t0     = cyc;
      push_expected(k);
      @(posedge clk); #1;
      start  = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      n = 0;
      while (!rk_valid && n < 40) begin
         start = inject && (n == 3);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check("first_valid", 128'(rk_valid), 128'(1));
      check("latency", 128'(cyc - t0), 128'(exp_lat));
      n = 0;
      while ((sb.size() != 0 || busy) && n < 400) begin
         start = inject && rk_valid && (round_idx == 4'd7 || round_idx == 4'd0);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check("drain", 128'(sb.size() != 0 || busy), 128'(0));
      repeat (2) @(posedge clk);
      #1;
      check("idle_after", 128'(busy), 128'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1;
      start = 1'b0;
      key_in = '0;
      rk_ready = 1'b1;
      build_tables();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // Known-answer schedule with full throughput.
      run_key(FIPS_KEY, 11, 1'b0);
      check("fips_rk10", cap10, FIPS_RK10);
      check("fips_rk1", cap1, FIPS_RK1);
      check("fips_rk0", cap0, FIPS_KEY);

      // Same key under random backpressure (a cache hit when the cache is built in).
      rand_ready = 1'b1;
      run_key(FIPS_KEY, HIT_LAT, 1'b0);
      check("bp_rk10", cap10, FIPS_RK10);
      rand_ready = 1'b0;

      // Starts in EXPAND, in EMIT and in the final handshake cycle must be ignored.
      run_key({$urandom, $urandom, $urandom, $urandom}, 11, 1'b1);

      // Reset in the middle of EMIT.
      @(posedge clk); #1;
      start = 1'b1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      push_expected(key_in);
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!(rk_valid && round_idx == 4'd5) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check("reach_idx5", 128'(rk_valid && round_idx == 4'd5), 128'(1));
      #1 rst = 1'b1;
      #1 check_zero("abort");
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      run_key(128'h0, 11, 1'b0);
      check("zero_rk10", cap10, ZERO_RK10);

      // Cache behaviour: repeat, different key, repeat after reset.
      run_key(128'h0, HIT_LAT, 1'b0);
      run_key({$urandom, $urandom, $urandom, $urandom}, 11, 1'b0);
      run_key(128'h0, 11, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      run_key(128'h0, 11, 1'b0);

      // Random keys under random backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 3; i++) run_key({$urandom, $urandom, $urandom, $urandom}, 11, 1'b0);
      rand_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
